// File: rtl/ir_queue_pkg.sv
// Shared types and sizing for the IFU->EXU instruction queue.
// XLEN, PC_SIZE and the default queue depth live here for the whole slice.
package ir_queue_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned PC_SIZE   = 32;
    localparam int unsigned IRQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0]    ir;
        logic [PC_SIZE-1:0] pc;
        logic               len16;
    } irq_entry_t;

    // Anything other than 2'b11 in the low opcode bits is a compressed encoding
    function automatic logic is_len16(input logic [XLEN-1:0] ir);
        return (ir[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Entry storage for ir_queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module ir_queue_mem
    import ir_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IRQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  irq_entry_t       i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output irq_entry_t       o_rdata
);

    irq_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ir_queue.sv
// Decoupling IR/PC queue between fetch and execute, flushed on pipe flush.
// Optional combinational empty-queue forwarding: define IR_QUEUE_BYPASS_EN.
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IRQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ifu_i_valid,
    output logic               ifu_o_ready,
    input  logic [XLEN-1:0]    ifu_i_ir,
    input  logic [PC_SIZE-1:0] ifu_i_pc,
    input  logic               flush_i,
    output logic               exu_o_valid,
    input  logic               exu_i_ready,
    output logic [XLEN-1:0]    exu_o_ir,
    output logic [PC_SIZE-1:0] exu_o_pc,
    output logic               exu_o_len16,
    output logic [PTR_W:0]     q_o_count
);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [PTR_W:0] r_count;

    logic       w_empty;
    logic       w_full;
    logic       w_byp;
    logic       w_push;
    logic       w_pop;
    irq_entry_t w_in;
    irq_entry_t w_head;
    irq_entry_t w_out;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]) &&
                     (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]);

    assign w_in = '{ir: ifu_i_ir, pc: ifu_i_pc, len16: is_len16(ifu_i_ir)};

`ifdef IR_QUEUE_BYPASS_EN
    assign w_byp = w_empty & ifu_i_valid & ~flush_i;
`else
    assign w_byp = 1'b0;
`endif

    // A bypassed entry taken by EXU in the same cycle is never written
    assign w_push = ifu_i_valid & ~w_full & ~flush_i & ~(w_byp & exu_i_ready);
    assign w_pop  = ~w_empty & ~flush_i & exu_i_ready;

    assign ifu_o_ready = ~w_full;
    assign exu_o_valid = (~w_empty | w_byp) & ~flush_i;

    assign w_out       = w_byp ? w_in : w_head;
    assign exu_o_ir    = exu_o_valid ? w_out.ir    : '0;
    assign exu_o_pc    = exu_o_valid ? w_out.pc    : '0;
    assign exu_o_len16 = exu_o_valid ? w_out.len16 : 1'b0;
    assign q_o_count   = r_count;

    ir_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (w_in),
        .i_raddr (r_rd_ptr[PTR_W-1:0]),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
